// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous
// display update, dead-time anode blanking and leading-zero suppression.
module seg_display_scan #(
  parameter int CLK_DIV  = 50000,
  parameter int DEAD_CYC = 2,
  parameter int LZB      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        load,
  input  logic [3:0]  dp_in,
  output logic [3:0]  q,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEAD_V  = CW'(DEAD_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_flag_q, pend_flag_d;
  logic [15:0]   disp_data_q, disp_data_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [3:0]    q_q, q_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          bound;
  logic [3:0]    zero;
  logic [3:0]    blank;
  logic          dead;

  assign tick  = (cnt_q == CNT_MAX);
  assign bound = tick && (sel_q == 2'd3);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    sel_d = tick ? sel_q + 2'd1 : sel_q;
  end

  // A load on the boundary cycle goes to pending; display takes the old one.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    if (bound && pend_flag_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_flag_d = 1'b0;
    end
    if (load) begin
      pend_data_d = data;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      zero[i] = (disp_data_q[i*4 +: 4] == 4'h0);
    end
    blank    = '0;
    if (LZB != 0) begin
      blank[3] = zero[3] & ~disp_dp_q[3];
      blank[2] = zero[3] & zero[2] & ~disp_dp_q[2];
      blank[1] = zero[3] & zero[2] & zero[1] & ~disp_dp_q[1];
    end
  end

  always_comb begin
    dead    = (cnt_q < DEAD_V);
    q_d     = disp_data_q[{sel_q, 2'b00} +: 4];
    an_d    = 4'hF;
    if (!dead && !blank[sel_q]) begin
      an_d  = ~(4'b0001 << sel_q);
    end
    dp_d    = (an_d == 4'hF) ? 1'b1 : ~disp_dp_q[sel_q];
    frame_d = bound;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sel_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      q_q         <= 4'h0;
      an_q        <= 4'hF;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      q_q         <= q_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign q     = q_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: two instances share stimulus,
// one without and one with leading-zero blanking.
module tb_seg_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  q0, an0, q1, an1;
  logic        dp0, frame0, dp1, frame1;

  int checks;
  int fails;

  seg_display_scan #(.CLK_DIV(4), .DEAD_CYC(1), .LZB(0)) u_dut0 (
    .clk(clk), .rst(rst), .data(data), .load(load), .dp_in(dp_in),
    .q(q0), .an(an0), .dp(dp0), .frame(frame0)
  );

  seg_display_scan #(.CLK_DIV(4), .DEAD_CYC(1), .LZB(1)) u_dut1 (
    .clk(clk), .rst(rst), .data(data), .load(load), .dp_in(dp_in),
    .q(q1), .an(an1), .dp(dp1), .frame(frame1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one 16-cycle frame starting at slot 0, cnt 0.
  // blank1: slots the LZB instance must keep dark.
  task automatic check_frame(
    input string tag, input logic [15:0] exp_q, input logic [3:0] exp_dp,
    input logic [3:0] blank1,
    input int lk0, input logic [15:0] ld0, input logic [3:0] lp0,
    input int lk1, input logic [15:0] ld1, input logic [3:0] lp1);
    int s;
    int c;
    logic [3:0] e_an0, e_an1, e_q;
    logic e_dp0, e_dp1;
    for (int k = 0; k < 16; k++) begin
      if (k == lk0) begin
        load = 1'b1; data = ld0; dp_in = lp0;
      end else if (k == lk1) begin
        load = 1'b1; data = ld1; dp_in = lp1;
      end
      step();
      load  = 1'b0;
      s     = k / 4;
      c     = k % 4;
      e_q   = exp_q[s*4 +: 4];
      e_an0 = (c == 0) ? 4'hF : ~(4'b0001 << s);
      e_an1 = (c == 0 || blank1[s]) ? 4'hF : ~(4'b0001 << s);
      e_dp0 = (e_an0 == 4'hF) ? 1'b1 : ~exp_dp[s];
      e_dp1 = (e_an1 == 4'hF) ? 1'b1 : ~exp_dp[s];
      check($sformatf("%s k%0d an0", tag, k), 16'(an0), 16'(e_an0));
      check($sformatf("%s k%0d q0", tag, k), 16'(q0), 16'(e_q));
      check($sformatf("%s k%0d dp0", tag, k), 16'(dp0), 16'(e_dp0));
      check($sformatf("%s k%0d frame0", tag, k), 16'(frame0),
            16'(k == 15));
      check($sformatf("%s k%0d an1", tag, k), 16'(an1), 16'(e_an1));
      check($sformatf("%s k%0d q1", tag, k), 16'(q1), 16'(e_q));
      check($sformatf("%s k%0d dp1", tag, k), 16'(dp1), 16'(e_dp1));
    end
  endtask

  task automatic check_reset_out(input string tag);
    check({tag, " an0"}, 16'(an0), 16'hF);
    check({tag, " q0"}, 16'(q0), 16'h0);
    check({tag, " dp0"}, 16'(dp0), 16'h1);
    check({tag, " frame0"}, 16'(frame0), 16'h0);
    check({tag, " an1"}, 16'(an1), 16'hF);
    check({tag, " q1"}, 16'(q1), 16'h0);
    check({tag, " dp1"}, 16'(dp1), 16'h1);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    load   = 1'b0;
    data   = 16'h0;
    dp_in  = 4'h0;
    step();
    step();
    check_reset_out("rst");
    rst = 1'b0;

    check_frame("f1_idle", 16'h0000, 4'h0, 4'b1110,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f2_ld", 16'h0000, 4'h0, 4'b1110,
                6, 16'h1A3F, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f3_1a3f", 16'h1A3F, 4'h0, 4'h0,
                3, 16'h1234, 4'h0, 9, 16'h5678, 4'h0);
    check_frame("f4_5678", 16'h5678, 4'h0, 4'h0,
                15, 16'h9ABC, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f5_hold", 16'h5678, 4'h0, 4'h0,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f6_9abc", 16'h9ABC, 4'h0, 4'h0,
                4, 16'hDEAD, 4'h0, 15, 16'hBEEF, 4'h0);
    check_frame("f7_dead", 16'hDEAD, 4'h0, 4'h0,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f8_beef", 16'hBEEF, 4'h0, 4'h0,
                2, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);
    check_frame("f9_lzb", 16'h0050, 4'b1000, 4'b0100,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    for (int k = 0; k < 9; k++) begin
      if (k == 5) begin
        load = 1'b1; data = 16'h7777; dp_in = 4'hF;
      end
      step();
      load = 1'b0;
    end
    rst = 1'b1;
    step();
    check_reset_out("midrst");
    step();
    rst = 1'b0;
    check_frame("f10_clr", 16'h0000, 4'h0, 4'b1110,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("f11_clr", 16'h0000, 4'h0, 4'b1110,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
